// File: rtl/immediate_generator.sv
// RV32I decode-stage immediate generator: opcode-driven format classification
// with a combinational immediate and an enable-captured registered copy.
// Optional CSR zimm decoding is enabled by defining IMMGEN_CSR_EN.
module immediate_generator (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        en,
    output logic [31:0] imm_out,
    output logic [2:0]  fmt,
    output logic [31:0] imm_q,
    output logic [2:0]  fmt_q,
    output logic        valid_q
);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } fmt_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [6:0] opcode;
    fmt_e       fmt_sel;

    assign opcode = instr[6:0];

    always_comb begin
        fmt_sel = FMT_NONE;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR: fmt_sel = FMT_I;
            OP_STORE:                 fmt_sel = FMT_S;
            OP_BRANCH:                fmt_sel = FMT_B;
            OP_LUI, OP_AUIPC:         fmt_sel = FMT_U;
            OP_JAL:                   fmt_sel = FMT_J;
`ifdef IMMGEN_CSR_EN
            // Only the immediate CSR forms (funct3[2] set) carry a zimm field.
            OP_SYSTEM:                fmt_sel = instr[14] ? FMT_Z : FMT_NONE;
`else
            OP_SYSTEM:                fmt_sel = FMT_NONE;
`endif
            default:                  fmt_sel = FMT_NONE;
        endcase
    end

    always_comb begin
        imm_out = 32'd0;
        case (fmt_sel)
            FMT_I: imm_out = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm_out = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm_out = {{19{instr[31]}}, instr[31], instr[7],
                              instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm_out = {instr[31:12], 12'b0};
            FMT_J: imm_out = {{11{instr[31]}}, instr[31], instr[19:12],
                              instr[20], instr[30:21], 1'b0};
            FMT_Z: imm_out = {27'b0, instr[19:15]};
            default: imm_out = 32'd0;
        endcase
    end

    assign fmt = fmt_sel;

    // valid_q marks only the cycle right after a capture; data holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm_q   <= 32'd0;
            fmt_q   <= 3'd0;
            valid_q <= 1'b0;
        end else if (en) begin
            imm_q   <= imm_out;
            fmt_q   <= fmt;
            valid_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_immediate_generator.sv
// Directed bench for immediate_generator: hand-computed immediates per format,
// register capture/hold, back-to-back capture and asynchronous reset.
module tb_immediate_generator;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        en;
    logic [31:0] imm_out;
    logic [2:0]  fmt;
    logic [31:0] imm_q;
    logic [2:0]  fmt_q;
    logic        valid_q;

    int checks = 0;
    int errors = 0;

    immediate_generator dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .instr   (instr),
        .en      (en),
        .imm_out (imm_out),
        .fmt     (fmt),
        .imm_q   (imm_q),
        .fmt_q   (fmt_q),
        .valid_q (valid_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic comb(input string tag, input logic [31:0] ins,
                        input logic [31:0] exp_imm, input logic [2:0] exp_fmt);
        instr = ins;
        #1;
        check({tag, "_imm"}, imm_out, exp_imm);
        check({tag, "_fmt"}, {29'd0, fmt}, {29'd0, exp_fmt});
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        instr = 32'h0000_0013;
        #12;
        check("rst_imm_q",   imm_q,            32'd0);
        check("rst_fmt_q",   {29'd0, fmt_q},   32'd0);
        check("rst_valid_q", {31'd0, valid_q}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;

        comb("addi_m1",  32'hFFF0_0093, 32'hFFFF_FFFF, 3'd1);
        comb("addi_10",  32'h00A0_0093, 32'h0000_000A, 3'd1);
        comb("sw_m8",    32'hFE11_2C23, 32'hFFFF_FFF8, 3'd2);
        comb("lui",      32'h1234_50B7, 32'h1234_5000, 3'd4);
        comb("beq_m8",   32'hFE20_8CE3, 32'hFFFF_FFF8, 3'd3);
        comb("beq_p8",   32'h0020_8463, 32'h0000_0008, 3'd3);
        comb("jal_p2k",  32'h0010_006F, 32'h0000_0800, 3'd5);
        comb("jal_m2k",  32'h801F_F06F, 32'hFFFF_F800, 3'd5);
        comb("add_r",    32'h0020_81B3, 32'h0000_0000, 3'd0);
        comb("slli",     32'h4050_9093, 32'h0000_0405, 3'd1);
`ifdef IMMGEN_CSR_EN
        comb("csrrwi",   32'h000F_D0F3, 32'h0000_001F, 3'd6);
`else
        comb("csrrwi",   32'h000F_D0F3, 32'h0000_0000, 3'd0);
`endif
        comb("csrrw",    32'h3000_90F3, 32'h0000_0000, 3'd0);
        check("idle_valid", {31'd0, valid_q}, 32'd0);

        // capture then hold
        @(negedge clk);
        instr = 32'hFFF0_0093;
        en    = 1'b1;
        @(posedge clk); #1;
        check("cap_imm_q",   imm_q,            32'hFFFF_FFFF);
        check("cap_fmt_q",   {29'd0, fmt_q},   32'd1);
        check("cap_valid_q", {31'd0, valid_q}, 32'd1);

        @(negedge clk);
        en    = 1'b0;
        instr = 32'h0020_8463;
        @(posedge clk); #1;
        check("hold_imm_q",   imm_q,            32'hFFFF_FFFF);
        check("hold_fmt_q",   {29'd0, fmt_q},   32'd1);
        check("hold_valid_q", {31'd0, valid_q}, 32'd0);

        // back-to-back captures
        @(negedge clk);
        en    = 1'b1;
        instr = 32'h00A0_0093;
        @(posedge clk); #1;
        check("b2b0_imm_q", imm_q, 32'h0000_000A);
        @(negedge clk);
        instr = 32'hFE11_2C23;
        @(posedge clk); #1;
        check("b2b1_imm_q",   imm_q,            32'hFFFF_FFF8);
        check("b2b1_fmt_q",   {29'd0, fmt_q},   32'd2);
        check("b2b1_valid_q", {31'd0, valid_q}, 32'd1);

        // async reset between edges
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_imm_q",   imm_q,            32'd0);
        check("arst_fmt_q",   {29'd0, fmt_q},   32'd0);
        check("arst_valid_q", {31'd0, valid_q}, 32'd0);
        check("arst_imm_out", imm_out,          32'hFFFF_FFF8);
        rst_n = 1'b1;
        en    = 1'b0;

        @(posedge clk); #1;
        check("post_rst_valid", {31'd0, valid_q}, 32'd0);

        @(negedge clk);
        en    = 1'b1;
        instr = 32'h1234_50B7;
        @(posedge clk); #1;
        check("first_cap_imm_q", imm_q,            32'h1234_5000);
        check("first_cap_fmt_q", {29'd0, fmt_q},   32'd4);
        check("first_cap_valid", {31'd0, valid_q}, 32'd1);

        @(negedge clk);
        en = 1'b0;
        #20;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
